lcd_timing_controller: RTL and testbench

- Dot-clock sequencer for the background renderer.
- Runs the per-line and per-frame timing and produces the drawline strobe that advances the renderer one line.
- Publishes LY, the STAT mode and the LYC coincidence flag, raises the VBlank and STAT interrupt pulses, and drives the VRAM/OAM CPU-access block signals used by the bus decoder.
- Sits beside the renderer and is clocked from the same clock as the data bus.

---
 rtl/lcd_timing_controller.sv | 157 +++++++++++++++
 tb/tb_lcd_timing_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_controller.sv
// Dot-clock line/frame sequencer: LY, dot, STAT mode, LYC flag, renderer and interrupt strobes, CPU access blocks.
// Latency: every output is registered and decoded from the counter state being entered on that clk edge.
// Backpressure: none; free-running whenever the LCD is enabled, held idle at line 0 / dot 0 otherwise.
module lcd_timing_controller #(
  parameter int DOTS_PER_LINE = 456,
  parameter int OAM_DOTS      = 80,
  parameter int XFER_DOTS     = 172,
  parameter int VISIBLE_LINES = 144,
  parameter int TOTAL_LINES   = 154
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_lcd_enable,
  input  logic [7:0] i_lyc,
  input  logic [3:0] i_stat_int_en,
  output logic [7:0] o_ly,
  output logic [8:0] o_dot,
  output logic [1:0] o_mode,
  output logic       o_coincidence,
  output logic       o_drawline,
  output logic       o_frame_start,
  output logic       o_vblank_irq,
  output logic       o_stat_irq,
  output logic       o_vram_block,
  output logic       o_oam_block
);

  localparam logic [8:0] LP_DOT_LAST  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] LP_OAM_END   = 9'(OAM_DOTS);
  localparam logic [8:0] LP_XFER_END  = 9'(OAM_DOTS + XFER_DOTS);
  localparam logic [7:0] LP_LY_LAST   = 8'(TOTAL_LINES - 1);
  localparam logic [7:0] LP_VIS_LINES = 8'(VISIBLE_LINES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_OAM    = 3'd1,
    S_XFER   = 3'd2,
    S_HBLANK = 3'd3,
    S_VBLANK = 3'd4
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [8:0] r_dot, w_dot_nxt;
  logic [7:0] r_ly, w_ly_nxt;
  logic [1:0] r_mode, w_mode_nxt;
  logic       r_coinc, w_coinc_nxt;
  logic       r_stat_line, w_stat_line_nxt;
  logic       r_drawline, w_drawline_nxt;
  logic       r_frame_start, w_frame_start_nxt;
  logic       r_vblank_irq, w_vblank_irq_nxt;
  logic       r_stat_irq, w_stat_irq_nxt;
  logic       r_vram_block, w_vram_block_nxt;
  logic       r_oam_block, w_oam_block_nxt;

  // Next counter position, FSM state and every output value for the cycle about to be entered.
  always_comb begin
    w_state_nxt       = S_IDLE;
    w_dot_nxt         = '0;
    w_ly_nxt          = '0;
    w_mode_nxt        = 2'd0;
    w_stat_line_nxt   = 1'b0;
    w_drawline_nxt    = 1'b0;
    w_frame_start_nxt = 1'b0;
    w_vblank_irq_nxt  = 1'b0;
    w_vram_block_nxt  = 1'b0;
    w_oam_block_nxt   = 1'b0;

    if (i_lcd_enable) begin
      // Coming out of idle lands on line 0, dot 0; otherwise advance one dot.
      if (r_state != S_IDLE) begin
        if (r_dot == LP_DOT_LAST) begin
          w_dot_nxt = '0;
          w_ly_nxt  = (r_ly == LP_LY_LAST) ? 8'd0 : r_ly + 8'd1;
        end else begin
          w_dot_nxt = r_dot + 9'd1;
          w_ly_nxt  = r_ly;
        end
      end

      // The state follows the counters, so OAM->XFER->HBLANK->(OAM|VBLANK)
      // and VBLANK->OAM at the line wrap fall out of the dot/line boundaries.
      if (w_ly_nxt >= LP_VIS_LINES)     w_state_nxt = S_VBLANK;
      else if (w_dot_nxt < LP_OAM_END)  w_state_nxt = S_OAM;
      else if (w_dot_nxt < LP_XFER_END) w_state_nxt = S_XFER;
      else                              w_state_nxt = S_HBLANK;

      case (w_state_nxt)
        S_OAM:    w_mode_nxt = 2'd2;
        S_XFER:   w_mode_nxt = 2'd3;
        S_VBLANK: w_mode_nxt = 2'd1;
        default:  w_mode_nxt = 2'd0;
      endcase

      w_oam_block_nxt   = (w_state_nxt == S_OAM) || (w_state_nxt == S_XFER);
      w_vram_block_nxt  = (w_state_nxt == S_XFER);
      w_drawline_nxt    = (w_state_nxt == S_XFER) && (w_dot_nxt == LP_OAM_END);
      w_frame_start_nxt = (w_ly_nxt == 8'd0) && (w_dot_nxt == 9'd0);
      w_vblank_irq_nxt  = (w_ly_nxt == LP_VIS_LINES) && (w_dot_nxt == 9'd0);
    end

    // Coincidence tracks the line being entered, also while idle.
    w_coinc_nxt = (w_ly_nxt == i_lyc);

    if (i_lcd_enable) begin
      w_stat_line_nxt = (i_stat_int_en[3] & w_coinc_nxt)
                      | (i_stat_int_en[2] & (w_mode_nxt == 2'd2))
                      | (i_stat_int_en[1] & (w_mode_nxt == 2'd1))
                      | (i_stat_int_en[0] & (w_mode_nxt == 2'd0));
    end

    // Only a rising edge of the combined line interrupts; overlapping sources stay merged.
    w_stat_irq_nxt = w_stat_line_nxt & ~r_stat_line;
  end

  // State register, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_IDLE;
      r_dot         <= '0;
      r_ly          <= '0;
      r_mode        <= 2'd0;
      r_coinc       <= 1'b0;
      r_stat_line   <= 1'b0;
      r_drawline    <= 1'b0;
      r_frame_start <= 1'b0;
      r_vblank_irq  <= 1'b0;
      r_stat_irq    <= 1'b0;
      r_vram_block  <= 1'b0;
      r_oam_block   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_dot         <= w_dot_nxt;
      r_ly          <= w_ly_nxt;
      r_mode        <= w_mode_nxt;
      r_coinc       <= w_coinc_nxt;
      r_stat_line   <= w_stat_line_nxt;
      r_drawline    <= w_drawline_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_vblank_irq  <= w_vblank_irq_nxt;
      r_stat_irq    <= w_stat_irq_nxt;
      r_vram_block  <= w_vram_block_nxt;
      r_oam_block   <= w_oam_block_nxt;
    end
  end

  assign o_ly          = r_ly;
  assign o_dot         = r_dot;
  assign o_mode        = r_mode;
  assign o_coincidence = r_coinc;
  assign o_drawline    = r_drawline;
  assign o_frame_start = r_frame_start;
  assign o_vblank_irq  = r_vblank_irq;
  assign o_stat_irq    = r_stat_irq;
  assign o_vram_block  = r_vram_block;
  assign o_oam_block   = r_oam_block;

endmodule

// File: tb/tb_lcd_timing_controller.sv
// Directed bench for lcd_timing_controller: line/frame timing, LYC, STAT edge logic, disable and async reset.
// Cycle c is the c-th rising edge after the controller leaves idle; outputs are sampled 1ns after that edge.
// Inputs are driven right after sampling, so they are seen at the following edge.
module tb_lcd_timing_controller;

  localparam int DPL   = 456;
  localparam int LINES = 154;
  localparam int FRAME = DPL * LINES;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       lcd_enable;
  logic [7:0] lyc;
  logic [3:0] stat_int_en;
  logic [7:0] ly;
  logic [8:0] dot;
  logic [1:0] mode;
  logic       coincidence, drawline, frame_start, vblank_irq, stat_irq, vram_block, oam_block;

  int n_checks = 0;
  int n_errors = 0;

  lcd_timing_controller dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_lcd_enable  (lcd_enable),
    .i_lyc         (lyc),
    .i_stat_int_en (stat_int_en),
    .o_ly          (ly),
    .o_dot         (dot),
    .o_mode        (mode),
    .o_coincidence (coincidence),
    .o_drawline    (drawline),
    .o_frame_start (frame_start),
    .o_vblank_irq  (vblank_irq),
    .o_stat_irq    (stat_irq),
    .o_vram_block  (vram_block),
    .o_oam_block   (oam_block)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Go idle for one edge, load new LYC / enables, and re-enable: the next tick is cycle 0.
  task automatic restart(input logic [7:0] lyc_v, input logic [3:0] en_v);
    lcd_enable = 1'b0;
    tick();
    lyc         = lyc_v;
    stat_int_en = en_v;
    lcd_enable  = 1'b1;
  endtask

  function automatic int exp_mode(input int c);
    int ln, d;
    ln = (c / DPL) % LINES;
    d  = c % DPL;
    if (ln >= 144)  return 1;
    else if (d < 80)  return 2;
    else if (d < 252) return 3;
    else              return 0;
  endfunction

  initial begin
    int n_draw, n_vbl, vbl_at, n_fs_mid, mode_err, blk_err, pos_err, draw_err, n_irq, em;

    reset_n     = 1'b0;
    lcd_enable  = 1'b1;
    lyc         = 8'd200;
    stat_int_en = 4'b0000;
    #12;
    check("rst_ly", int'(ly), 0);
    check("rst_dot", int'(dot), 0);
    check("rst_mode", int'(mode), 0);
    check("rst_blocks", int'({oam_block, vram_block}), 0);
    check("rst_coinc", int'(coincidence), 0);
    check("rst_strobes", int'({drawline, frame_start, vblank_irq, stat_irq}), 0);
    reset_n = 1'b1;

    // One full frame plus the first cycle of the next one.
    n_draw = 0; n_vbl = 0; vbl_at = -1; n_fs_mid = 0;
    mode_err = 0; blk_err = 0; pos_err = 0; draw_err = 0;
    for (int c = 0; c <= FRAME; c++) begin
      tick();
      if (c < FRAME) begin
        em = exp_mode(c);
        if (int'(mode) != em) mode_err++;
        if (int'(oam_block) != int'(em >= 2)) blk_err++;
        if (int'(vram_block) != int'(em == 3)) blk_err++;
        if (int'(dot) != c % DPL || int'(ly) != c / DPL) pos_err++;
        if (drawline) begin
          n_draw++;
          if (c % DPL != 80) draw_err++;
        end
        if (vblank_irq) begin
          n_vbl++;
          vbl_at = c;
        end
        if (frame_start && c != 0) n_fs_mid++;
      end
      if (c == 0) begin
        check("c0_frame_start", int'(frame_start), 1);
        check("c0_mode", int'(mode), 2);
      end
      if (c == 79)  check("dot79_mode", int'(mode), 2);
      if (c == 80) begin
        check("dot80_mode", int'(mode), 3);
        check("dot80_drawline", int'(drawline), 1);
      end
      if (c == 251) check("dot251_mode", int'(mode), 3);
      if (c == 252) check("dot252_mode", int'(mode), 0);
      if (c == 456) check("c456_ly", int'(ly), 1);
      if (c == 144 * DPL) begin
        check("vbl_mode", int'(mode), 1);
        check("vbl_ly", int'(ly), 144);
      end
      if (c == FRAME) begin
        check("wrap_frame_start", int'(frame_start), 1);
        check("wrap_ly", int'(ly), 0);
        check("wrap_dot", int'(dot), 0);
        check("wrap_mode", int'(mode), 2);
      end
    end
    check("frame_drawlines", n_draw, 144);
    check("frame_drawline_pos", draw_err, 0);
    check("frame_vblank_count", n_vbl, 1);
    check("frame_vblank_cycle", vbl_at, 144 * DPL);
    check("frame_start_mid", n_fs_mid, 0);
    check("frame_mode_errs", mode_err, 0);
    check("frame_block_errs", blk_err, 0);
    check("frame_pos_errs", pos_err, 0);

    // LYC=5 with only the coincidence source enabled.
    restart(8'd5, 4'b1000);
    n_irq = 0;
    for (int c = 0; c <= 6 * DPL; c++) begin
      tick();
      if (stat_irq) n_irq++;
      if (c == 5 * DPL - 1) check("lyc5_before", int'(coincidence), 0);
      if (c == 5 * DPL) begin
        check("lyc5_coinc", int'(coincidence), 1);
        check("lyc5_irq", int'(stat_irq), 1);
      end
      if (c == 6 * DPL) check("lyc5_clear", int'(coincidence), 0);
    end
    check("lyc5_irq_count", n_irq, 1);

    // Mid-line LYC write on line 3.
    restart(8'd5, 4'b1000);
    for (int c = 0; c <= 3 * DPL + 200; c++) tick();
    lyc = 8'd3;
    check("lyc3_pre", int'(coincidence), 0);
    tick();
    check("lyc3_coinc", int'(coincidence), 1);
    check("lyc3_irq", int'(stat_irq), 1);
    tick();
    check("lyc3_irq_once", int'(stat_irq), 0);

    // Mode 0 + mode 2 sources: HBlank->OAM hand-off stays high without a new pulse.
    restart(8'd200, 4'b0101);
    n_irq = 0;
    for (int c = 0; c <= DPL + 252; c++) begin
      tick();
      if (stat_irq) n_irq++;
      if (c == 0)   check("m02_c0_irq", int'(stat_irq), 1);
      if (c == 252) check("m02_l0_hblank_irq", int'(stat_irq), 1);
      if (c == DPL) begin
        check("m02_l1_blocked", int'(stat_irq), 0);
        check("m02_l1_mode", int'(mode), 2);
      end
      if (c == DPL + 252) check("m02_l1_hblank_irq", int'(stat_irq), 1);
    end
    check("m02_irq_count", n_irq, 3);

    // Disable mid-line at line 10, dot 100.
    restart(8'd200, 4'b0000);
    for (int c = 0; c <= 10 * DPL + 100; c++) tick();
    check("dis_pre_pos", int'({ly, 7'd0, dot}), int'({8'd10, 7'd0, 9'd100}));
    check("dis_pre_vram", int'(vram_block), 1);
    lcd_enable = 1'b0;
    tick();
    check("dis_ly", int'(ly), 0);
    check("dis_dot", int'(dot), 0);
    check("dis_mode", int'(mode), 0);
    check("dis_blocks", int'({oam_block, vram_block}), 0);
    check("dis_strobes", int'({drawline, frame_start, vblank_irq, stat_irq}), 0);
    tick();
    check("idle_strobes", int'({drawline, frame_start, vblank_irq, stat_irq}), 0);
    lcd_enable = 1'b1;
    tick();
    check("reen_frame_start", int'(frame_start), 1);
    check("reen_mode", int'(mode), 2);
    check("reen_oam_block", int'(oam_block), 1);

    // Asynchronous reset in mode 3, between clock edges.
    for (int c = 0; c < 100; c++) tick();
    check("ares_pre_vram", int'(vram_block), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ares_mode", int'(mode), 0);
    check("ares_blocks", int'({oam_block, vram_block}), 0);
    check("ares_pos", int'({ly, dot}), 0);
    #10;
    reset_n = 1'b1;
    tick();
    check("ares_restart_fs", int'(frame_start), 1);
    check("ares_restart_mode", int'(mode), 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
